// File: rtl/reg_bank.sv
// reg_bank: MIPS general-purpose register file.
// Provides two bypassed read ports for decode and one write port for WB.
// Also has a committed-only debug read port and a saturating count of
// committed writes. Entry 0 is hardwired to zero.
module reg_bank #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] readReg1,
   input  logic [ADDR_W-1:0] readReg2,
   input  logic [ADDR_W-1:0] writeReg,
   input  logic [DATA_W-1:0] writeData,
   input  logic              regWrite,
   input  logic              enableDebug,
   input  logic              resetDebug,
   input  logic [ADDR_W-1:0] debugAddr,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2,
   output logic [DATA_W-1:0] debugData,
   output logic [CNT_W-1:0]  writeCount
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [NREG];
   logic              we;

   // Commit qualifier. It is gated by reset so that the bypass cannot leak
   // writeData while the bank is held in reset.
   always_comb begin
      we = regWrite & enableDebug & ~resetDebug & (writeReg != '0) & reset;
   end

   // Storage and write counter: async clear, sync debug clear, then commit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem        <= '{default: '0};
         writeCount <= '0;
      end else if (resetDebug) begin
         mem        <= '{default: '0};
         writeCount <= '0;
      end else if (we) begin
         mem[writeReg] <= writeData;
         if (writeCount != '1)
            writeCount <= writeCount + CNT_W'(1);
      end
   end

   // Read ports: zero register first, then WB bypass, then stored value.
   always_comb begin
      readData1 = '0;
      readData2 = '0;
      if (readReg1 != '0)
         readData1 = (we && (writeReg == readReg1)) ? writeData : mem[readReg1];
      if (readReg2 != '0)
         readData2 = (we && (writeReg == readReg2)) ? writeData : mem[readReg2];
   end

   // Debug port shows committed state only.
   always_comb begin
      debugData = (debugAddr == '0) ? '0 : mem[debugAddr];
   end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed vectors for reg_bank with hand-computed expectations.
// A second instance with a 4-bit counter shares the stimulus so that counter
// saturation can be observed.
module tb_reg_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  readReg1, readReg2, writeReg, debugAddr;
   logic [31:0] writeData;
   logic        regWrite, enableDebug, resetDebug;
   logic [31:0] readData1, readData2, debugData, writeCount;
   logic [31:0] rdS1, rdS2, dbgS;
   logic [3:0]  cntS;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   reg_bank dut (
      .clk(clk), .reset(reset), .readReg1(readReg1), .readReg2(readReg2),
      .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
      .enableDebug(enableDebug), .resetDebug(resetDebug), .debugAddr(debugAddr),
      .readData1(readData1), .readData2(readData2), .debugData(debugData),
      .writeCount(writeCount)
   );

   reg_bank #(.CNT_W(4)) dutSmall (
      .clk(clk), .reset(reset), .readReg1(readReg1), .readReg2(readReg2),
      .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
      .enableDebug(enableDebug), .resetDebug(resetDebug), .debugAddr(debugAddr),
      .readData1(rdS1), .readData2(rdS2), .debugData(dbgS),
      .writeCount(cntS)
   );

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One committed write: drive on the falling edge, release after the rising edge.
   task automatic writeReg1(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      regWrite = 1'b1; writeReg = a; writeData = d;
      @(posedge clk); #1;
      regWrite = 1'b0;
   endtask

   initial begin
      reset = 1'b0; readReg1 = '0; readReg2 = '0; writeReg = '0; debugAddr = '0;
      writeData = '0; regWrite = 1'b0; enableDebug = 1'b1; resetDebug = 1'b0;

      // reset state
      @(negedge clk);
      readReg1 = 5'd5; readReg2 = 5'd7; debugAddr = 5'd5;
      #1;
      checkValue("rst_rd1", readData1, 32'h0);
      checkValue("rst_rd2", readData2, 32'h0);
      checkValue("rst_dbg", debugData, 32'h0);
      checkValue("rst_cnt", writeCount, 32'd0);
      reset = 1'b1;

      // 1: async reset mid-run, then write after release
      writeReg1(5'd5, 32'h1234);
      checkValue("t1_pre_rd1", readData1, 32'h1234);
      checkValue("t1_pre_cnt", writeCount, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkValue("t1_rst_rd1", readData1, 32'h0);
      checkValue("t1_rst_cnt", writeCount, 32'd0);
      #2 reset = 1'b1;
      writeReg1(5'd5, 32'hA5A5A5A5);
      checkValue("t1_rd1", readData1, 32'hA5A5A5A5);
      checkValue("t1_cnt", writeCount, 32'd1);

      // 2: writes to the zero register are ignored
      @(negedge clk);
      readReg1 = 5'd0; regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFFFFFF;
      #1;
      checkValue("t2_pre_rd1", readData1, 32'h0);
      @(posedge clk); #1;
      checkValue("t2_post_rd1", readData1, 32'h0);
      checkValue("t2_cnt", writeCount, 32'd1);
      regWrite = 1'b0;

      // 3: WB bypass on both ports; debug port sees committed value only
      writeReg1(5'd7, 32'h11);
      @(negedge clk);
      readReg1 = 5'd7; readReg2 = 5'd7; debugAddr = 5'd7;
      regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h22;
      #1;
      checkValue("t3_byp_rd1", readData1, 32'h22);
      checkValue("t3_byp_rd2", readData2, 32'h22);
      checkValue("t3_pre_dbg", debugData, 32'h11);
      @(posedge clk); #1;
      checkValue("t3_post_dbg", debugData, 32'h22);
      checkValue("t3_cnt", writeCount, 32'd3);
      regWrite = 1'b0;

      // 4: freeze suppresses commit and bypass
      @(negedge clk);
      enableDebug = 1'b0; regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h55;
      readReg1 = 5'd3; readReg2 = 5'd7;
      #1;
      checkValue("t4_frz_byp", readData1, 32'h0);
      checkValue("t4_frz_rd2", readData2, 32'h22);
      @(posedge clk); #1;
      checkValue("t4_frz_rd1", readData1, 32'h0);
      checkValue("t4_frz_cnt", writeCount, 32'd3);
      @(negedge clk);
      enableDebug = 1'b1;
      #1;
      checkValue("t4_run_byp", readData1, 32'h55);
      @(posedge clk); #1;
      regWrite = 1'b0;
      #1;
      checkValue("t4_run_rd1", readData1, 32'h55);
      checkValue("t4_run_cnt", writeCount, 32'd4);

      // 5: debug clear overrides a simultaneous write
      for (int i = 1; i < 32; i++) writeReg1(5'(i), 32'(i));
      @(negedge clk);
      readReg1 = 5'd9; readReg2 = 5'd31; debugAddr = 5'd20;
      #1;
      checkValue("t5_ld_rd1", readData1, 32'd9);
      checkValue("t5_ld_rd2", readData2, 32'd31);
      checkValue("t5_ld_dbg", debugData, 32'd20);
      checkValue("t5_ld_cnt", writeCount, 32'd35);
      @(negedge clk);
      resetDebug = 1'b1; regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h99;
      #1;
      checkValue("t5_nobyp", readData1, 32'd9);
      @(posedge clk); #1;
      checkValue("t5_clr_rd1", readData1, 32'h0);
      checkValue("t5_clr_cnt", writeCount, 32'd0);
      checkValue("t5_clr_cntS", {28'h0, cntS}, 32'd0);
      @(negedge clk);
      resetDebug = 1'b0; regWrite = 1'b0;
      for (int i = 1; i < 32; i++) begin
         debugAddr = 5'(i);
         #1;
         checkValue($sformatf("t5_clr_R%0d", i), debugData, 32'h0);
      end

      // 6: counter saturation on the 4-bit instance
      for (int k = 0; k < 20; k++) writeReg1(5'd2, 32'(k + 100));
      checkValue("t6_cnt", writeCount, 32'd20);
      checkValue("t6_cntS", {28'h0, cntS}, 32'd15);
      writeReg1(5'd4, 32'hBEEF);
      checkValue("t6_cnt_more", writeCount, 32'd21);
      checkValue("t6_cntS_hold", {28'h0, cntS}, 32'd15);
      @(negedge clk);
      readReg1 = 5'd2; readReg2 = 5'd4;
      #1;
      checkValue("t6_rd1", readData1, 32'd119);
      checkValue("t6_rd2", readData2, 32'hBEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- General-purpose register file for the 5-stage MIPS pipeline, upstream of the ID/EX latch.
- Provides two combinational read ports indexed by rs/rt during decode; their outputs are the readData1/readData2 values the ID/EX latch captures on the falling clock edge.
- Accepts one write per cycle from the WB stage on the rising edge.
- Honours the debug-unit controls (step freeze, debug clear) and exposes a third read port plus a write counter for the UART register dump.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  in  1  pipeline clock; writes on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all registers and the counter.
- readReg1  in  ADDR_W  rs index from IF/ID instruction.
- readReg2  in  ADDR_W  rt index from IF/ID instruction.
- writeReg  in  ADDR_W  destination index from MEM/WB.
- writeData  in  DATA_W  result from WB mux.
- regWrite  in  1  write enable from MEM/WB.
- enableDebug  in  1  1 = pipeline running/stepping; 0 = frozen, writes suppressed.
- resetDebug  in  1  synchronous clear request from debug unit.
- debugAddr  in  ADDR_W  register index requested by the debug dump.
- readData1  out  DATA_W  value of readReg1, with WB bypass.
- readData2  out  DATA_W  value of readReg2, with WB bypass.
- debugData  out  DATA_W  stored value of debugAddr, no bypass.
- writeCount  out  CNT_W  number of committed register writes since last clear.

Behaviour:
- Storage: 2**ADDR_W entries of DATA_W. Entry 0 reads as 0 always. Writes to index 0 are discarded, never stored, never counted.
- Async reset (reset=0): all entries = 0 and writeCount = 0, immediately and independent of clk. While reset=0, readData1/readData2/debugData all read 0 and writeCount = 0. Release takes effect at the next rising edge.
- Commit condition, evaluated on rising clk: we = regWrite & enableDebug & ~resetDebug & (writeReg != 0).
  - When we=1: mem[writeReg] <= writeData; writeCount <= writeCount + 1, saturating at all-ones.
- resetDebug=1 at a rising edge:
  - Clears all entries and writeCount to 0 in that cycle.
  - Overrides a simultaneous write, which is lost.
  - Applies regardless of enableDebug.
- enableDebug=0: no commit and no counter change. Reads remain live, so the debug dump and a frozen ID/EX see stable values.
- Read ports are combinational with a write-through bypass.
  - If we=1 and writeReg == readRegN, then readDataN = writeData in the same cycle.
  - Otherwise readDataN = mem[readRegN].
  - The bypass makes a same-cycle WB-to-ID dependency visible at the ID/EX negedge capture without a stall.
- Index 0 never bypasses: readRegN == 0 always gives 0.
- resetDebug=1 suppresses the bypass; reads show stored (pre-clear) values until the edge.
- debugData = mem[debugAddr], combinational, no bypass. It reflects only committed state.
- Both read ports may address the same register and each other's index; the outputs are independent.
- Latency:
  - Write-to-read through storage: 0 cycles after the rising edge.
  - Through bypass: 0 cycles, combinational.
  - No internal pipeline registers other than storage and the counter.
- writeCount saturates at 2**CNT_W-1 and never wraps.

Test Plan:
1. Reset: reset=0 mid-run after writing R5=0x1234 -> readData1 (readReg1=5) = 0 immediately, writeCount=0. Release, then write R5=0xA5A5A5A5 -> read = 0xA5A5A5A5, writeCount=1.
2. Zero register: regWrite=1, writeReg=0, writeData=0xFFFFFFFF -> readData1 (readReg1=0) = 0 before and after the edge; writeCount unchanged.
3. Bypass: readReg1=readReg2=7, R7=0x11, WB writes 0x22 to R7 -> both reads = 0x22 before the rising edge; debugData (debugAddr=7) = 0x11 until the edge, then 0x22.
4. Freeze: enableDebug=0, regWrite=1, writeReg=3, writeData=0x55 -> R3 unchanged, no bypass, writeCount unchanged. Set enableDebug=1 for one cycle -> R3=0x55, writeCount+1.
5. Debug clear vs write: load R1..R31 with index values, then resetDebug=1 with a simultaneous write R9=0x99 -> after the edge all of R1..R31 = 0 (R9=0) and writeCount=0.
6. Saturation: CNT_W=4, 20 consecutive commits -> writeCount = 15 and holds at 15.
